// File: rtl/rst_ce_sequencer.sv
// Drives a downstream block's synchronous reset and clock enable as a
// programmable RST -> GAP -> CE sequence, ending in a one-cycle done pulse.
module rst_ce_sequencer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_RST = 2,
  parameter int unsigned DEF_GAP = 0,
  parameter int unsigned DEF_CE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             use_def,
  input  logic [CNT_W-1:0] rst_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [CNT_W-1:0] ce_len,
  output logic             dut_rst,
  output logic             dut_ce,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             start_drop,
  output logic [CNT_W-1:0] phase_cnt
);

  localparam logic [CNT_W-1:0] L_DEF_RST = CNT_W'(DEF_RST);
  localparam logic [CNT_W-1:0] L_DEF_GAP = CNT_W'(DEF_GAP);
  localparam logic [CNT_W-1:0] L_DEF_CE  = CNT_W'(DEF_CE);
  localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_GAP,
    S_CE,
    S_DONE,
    S_ABRT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_gap_len;
  logic [CNT_W-1:0] r_ce_len;
  logic [CNT_W-1:0] w_next_cnt;
  logic [CNT_W-1:0] w_rst_eff;
  logic [CNT_W-1:0] w_gap_eff;
  logic [CNT_W-1:0] w_ce_eff;
  logic [CNT_W-1:0] w_lr;
  logic [CNT_W-1:0] w_lg;
  logic [CNT_W-1:0] w_lc;
  logic             w_sel;

  always_comb begin
    w_rst_eff = (use_def && (rst_len == '0)) ? L_DEF_RST : rst_len;
    w_gap_eff = use_def ? L_DEF_GAP : gap_len;
    w_ce_eff  = (use_def && (ce_len == '0)) ? L_DEF_CE : ce_len;
  end

  // Phase selection takes the remaining lengths (already-finished phases
  // passed as zero) so zero-length phases are skipped without a bubble.
  always_comb begin
    w_next     = r_state;
    w_next_cnt = r_cnt;
    w_lr       = '0;
    w_lg       = '0;
    w_lc       = '0;
    w_sel      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_cnt = '0;
        if (start) begin
          w_lr  = w_rst_eff;
          w_lg  = w_gap_eff;
          w_lc  = w_ce_eff;
          w_sel = 1'b1;
        end
      end
      S_RST, S_GAP, S_CE: begin
        if (abort) begin
          w_next     = S_ABRT;
          w_next_cnt = '0;
        end else if (r_cnt == L_ONE) begin
          w_lg  = (r_state == S_RST) ? r_gap_len : '0;
          w_lc  = (r_state != S_CE) ? r_ce_len : '0;
          w_sel = 1'b1;
        end else begin
          w_next_cnt = r_cnt - L_ONE;
        end
      end
      S_DONE, S_ABRT: begin
        w_next     = S_IDLE;
        w_next_cnt = '0;
      end
      default: begin
        w_next     = S_IDLE;
        w_next_cnt = '0;
      end
    endcase

    if (w_sel) begin
      if (w_lr != '0) begin
        w_next     = S_RST;
        w_next_cnt = w_lr;
      end else if (w_lg != '0) begin
        w_next     = S_GAP;
        w_next_cnt = w_lg;
      end else if (w_lc != '0) begin
        w_next     = S_CE;
        w_next_cnt = w_lc;
      end else begin
        w_next     = S_DONE;
        w_next_cnt = '0;
      end
    end
  end

  // The reset length goes straight into the counter, so only gap/ce are kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_gap_len  <= '0;
      r_ce_len   <= '0;
      dut_rst    <= 1'b0;
      dut_ce     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      start_drop <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_next_cnt;
      if ((r_state == S_IDLE) && start) begin
        r_gap_len <= w_gap_eff;
        r_ce_len  <= w_ce_eff;
      end
      dut_rst    <= (w_next == S_RST);
      dut_ce     <= (w_next == S_CE);
      busy       <= (w_next == S_RST) || (w_next == S_GAP) || (w_next == S_CE);
      done       <= (w_next == S_DONE);
      aborted    <= (w_next == S_ABRT);
      start_drop <= start && (r_state != S_IDLE);
    end
  end

  assign phase_cnt = r_cnt;

endmodule

// File: tb/tb_rst_ce_sequencer.sv
// Self-checking bench: a cycle-window model of the sequence is compared
// against every output each cycle, plus literal per-scenario expectations.
module tb_rst_ce_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       use_def = 1'b0;
  logic [7:0] rst_len = '0;
  logic [7:0] gap_len = '0;
  logic [7:0] ce_len = '0;
  logic       dut_rst, dut_ce, busy, done, aborted, start_drop;
  logic [7:0] phase_cnt;

  rst_ce_sequencer #(
    .CNT_W  (8),
    .DEF_RST(2),
    .DEF_GAP(0),
    .DEF_CE (2)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .use_def   (use_def),
    .rst_len   (rst_len),
    .gap_len   (gap_len),
    .ce_len    (ce_len),
    .dut_rst   (dut_rst),
    .dut_ce    (dut_ce),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .start_drop(start_drop),
    .phase_cnt (phase_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: one run described by its start edge, lengths and optional abort edge.
  int cyc = 0;
  bit mv = 1'b0;
  int mk = 0, mN = 0, mG = 0, mM = 0;
  int ma = -1;
  int drop_cyc = -1;

  function automatic int run_end();
    return (ma >= 0) ? ma + 1 : mk + mN + mG + mM + 1;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      mv = 1'b0;
    end else begin
      if (mv && ma < 0 && abort && cyc > mk && cyc <= mk + mN + mG + mM)
        ma = cyc;
      if (start) begin
        if (!mv || cyc > run_end()) begin
          mv = 1'b1;
          mk = cyc;
          mN = (use_def && rst_len == 0) ? 2 : int'(rst_len);
          mG = use_def ? 0 : int'(gap_len);
          mM = (use_def && ce_len == 0) ? 2 : int'(ce_len);
          ma = -1;
        end else begin
          drop_cyc = cyc + 1;
        end
      end
    end
    cyc = cyc + 1;
  end

  function automatic logic [13:0] exp_vec(input int c);
    logic r, e, b, d, ab, dr;
    int cnt, t, last;
    r = 0; e = 0; b = 0; d = 0; ab = 0; cnt = 0;
    dr = (drop_cyc == c);
    if (mv && c > mk) begin
      t    = mN + mG + mM;
      last = (ma >= 0) ? ma : mk + t;
      if (c <= last) begin
        b = 1;
        if (c <= mk + mN) begin
          r = 1; cnt = mk + mN - c + 1;
        end else if (c <= mk + mN + mG) begin
          cnt = mk + mN + mG - c + 1;
        end else begin
          e = 1; cnt = mk + t - c + 1;
        end
      end else if (c == last + 1) begin
        if (ma >= 0) ab = 1;
        else d = 1;
      end
    end
    return {r, e, b, d, ab, dr, 8'(cnt)};
  endfunction

  int n_rst, n_ce, n_busy, n_done, n_abrt, n_drop, done_cyc;

  always @(negedge clk) begin
    logic [13:0] ev;
    ev = rst ? exp_vec(cyc) : 14'h0;
    chk($sformatf("cyc%0d_outputs", cyc),
        longint'({dut_rst, dut_ce, busy, done, aborted, start_drop, phase_cnt}),
        longint'(ev));
    chk($sformatf("cyc%0d_rst_ce_overlap", cyc), longint'(dut_rst & dut_ce), 0);
    if (dut_rst) n_rst++;
    if (dut_ce) n_ce++;
    if (busy) n_busy++;
    if (aborted) n_abrt++;
    if (start_drop) n_drop++;
    if (done) begin
      n_done++;
      if (done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic clr();
    n_rst = 0; n_ce = 0; n_busy = 0; n_done = 0; n_abrt = 0; n_drop = 0;
    done_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns with the bench in the first cycle after the start edge; the cfg
  // inputs are then scrambled to show that latched values are used.
  task automatic kick(input bit ud, input int rl, input int gl, input int cl, output int k);
    @(posedge clk); #1;
    use_def = ud;
    rst_len = 8'(rl);
    gap_len = 8'(gl);
    ce_len  = 8'(cl);
    start   = 1'b1;
    k       = cyc;
    @(posedge clk); #1;
    start   = 1'b0;
    rst_len = 8'($urandom_range(1, 255));
    gap_len = 8'($urandom_range(1, 255));
    ce_len  = 8'($urandom_range(1, 255));
    use_def = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    #1 rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);

    // Defaults 2/0/2; the nonzero gap input must be overridden by DEF_GAP.
    clr();
    kick(1'b1, 0, 7, 0, k);
    idle(8);
    chk("def_rst_cycles", n_rst, 2);
    chk("def_ce_cycles", n_ce, 2);
    chk("def_done_ofs", done_cyc - k, 5);
    chk("def_done_count", n_done, 1);

    clr();
    kick(1'b0, 2, 1, 2, k);
    idle(8);
    chk("g1_rst_cycles", n_rst, 2);
    chk("g1_ce_cycles", n_ce, 2);
    chk("g1_done_ofs", done_cyc - k, 6);
    chk("g1_busy_cycles", n_busy, 5);

    clr();
    kick(1'b0, 0, 0, 3, k);
    idle(6);
    chk("ce_only_rst_cycles", n_rst, 0);
    chk("ce_only_ce_cycles", n_ce, 3);
    chk("ce_only_done_ofs", done_cyc - k, 4);

    clr();
    kick(1'b0, 0, 0, 0, k);
    idle(4);
    chk("zero_done_ofs", done_cyc - k, 1);
    chk("zero_busy_cycles", n_busy, 0);

    // Abort in the second CE cycle (CE occupies k+5..k+8).
    clr();
    kick(1'b0, 4, 0, 4, k);
    idle(5);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    idle(6);
    chk("abort_ce_cycles", n_ce, 2);
    chk("abort_pulses", n_abrt, 1);
    chk("abort_done_count", n_done, 0);

    // Start during RST (cycle k+1) and during DONE (cycle k+6).
    clr();
    kick(1'b0, 3, 0, 2, k);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(4);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(4);
    chk("drop_pulses", n_drop, 2);
    chk("drop_done_ofs", done_cyc - k, 6);
    chk("drop_rst_cycles", n_rst, 3);

    // Async reset during GAP (k+4..k+8), held for two edges.
    clr();
    kick(1'b0, 3, 5, 3, k);
    idle(4);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(3);
    chk("rstmid_done_count", n_done, 0);
    chk("rstmid_abort_count", n_abrt, 0);
    chk("rstmid_rst_cycles", n_rst, 3);
    chk("rstmid_ce_cycles", n_ce, 0);

    clr();
    kick(1'b0, 3, 5, 3, k);
    idle(15);
    chk("rerun_done_ofs", done_cyc - k, 12);
    chk("rerun_rst_cycles", n_rst, 3);
    chk("rerun_ce_cycles", n_ce, 3);

    clr();
    kick(1'b0, 255, 0, 1, k);
    idle(260);
    chk("max_rst_cycles", n_rst, 255);
    chk("max_rst_done_ofs", done_cyc - k, 257);

    clr();
    kick(1'b0, 255, 255, 255, k);
    idle(770);
    chk("max_all_ce_cycles", n_ce, 255);
    chk("max_all_busy_cycles", n_busy, 765);
    chk("max_all_done_ofs", done_cyc - k, 766);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
